// File: rtl/sequence_detector_pkg.sv
// ---------------------------------------------------------------------------
// sequence_detector_pkg
//
// Purpose:
//   Shared definitions for the "1011" Moore sequence detector: the 3-bit
//   binary state encoding and the pattern being searched for.
//
// Contents:
//   state_t     - 3-bit state type, S0..S4 (codes 3'b101..3'b111 are illegal)
//   PATTERN     - the detected bit pattern, first bit in the MSB
//   PATTERN_LEN - number of bits in PATTERN
// ---------------------------------------------------------------------------
package sequence_detector_pkg;

  // S0: idle, S1: "1", S2: "10", S3: "101", S4: "1011" just completed
  typedef enum logic [2:0] {
    S0 = 3'b000,
    S1 = 3'b001,
    S2 = 3'b010,
    S3 = 3'b011,
    S4 = 3'b100
  } state_t;

  localparam logic [3:0] PATTERN     = 4'b1011;
  localparam int         PATTERN_LEN = 4;

endpackage

// File: rtl/sequence_detector_moore.sv
// ---------------------------------------------------------------------------
// sequence_detector_moore
//
// Purpose:
//   Moore FSM that detects the serial pattern "1011" with overlap. One bit
//   is consumed on every rising clock edge; detector_out is high for the one
//   cycle the FSM spends in S4.
//
// Ports:
//   clock        in  1  system clock, rising-edge active
//   reset        in  1  asynchronous, active-high; forces S0 immediately
//   sequence_in  in  1  serial data bit, sampled on each rising edge
//   detector_out out 1  high while in S4 (pattern just completed)
// ---------------------------------------------------------------------------
module sequence_detector_moore
  import sequence_detector_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic sequence_in,
  output logic detector_out
);

  state_t current_state;
  state_t next_state;

  // State register. Reset is asynchronous so a partial pattern is discarded
  // the moment reset rises, not at the next clock edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      current_state <= S0;
    end else begin
      current_state <= next_state;
    end
  end

  // Next-state logic. From S4 the final "1" of the hit is reused as the
  // first bit of the next pattern, which is what gives overlapping detection:
  // a 1 restarts at S1 and a 0 lands in S2 ("10" already seen). Illegal
  // encodings fall back to S0 regardless of the input.
  always_comb begin
    next_state = S0;
    case (current_state)
      S0:      next_state = sequence_in ? S1 : S0;
      S1:      next_state = sequence_in ? S1 : S2;
      S2:      next_state = sequence_in ? S3 : S0;
      S3:      next_state = sequence_in ? S4 : S2;
      S4:      next_state = sequence_in ? S1 : S2;
      default: next_state = S0;
    endcase
  end

  // Moore output: decoded from the state register only, so there is no
  // combinational path from sequence_in to detector_out.
  assign detector_out = (current_state == S4);

endmodule

// File: tb/tb_sequence_detector_moore.sv
// ---------------------------------------------------------------------------
// tb_sequence_detector_moore
//
// Purpose:
//   Directed, self-checking bench for the "1011" Moore detector. Each step
//   drives one bit, waits for the rising edge and then compares the state
//   register and output against hand-computed values.
// ---------------------------------------------------------------------------
module tb_sequence_detector_moore;
  import sequence_detector_pkg::*;

  logic clock;
  logic reset;
  logic sequence_in;
  logic detector_out;

  int assertCount;
  int failCount;

  sequence_detector_moore dut (
    .clock        (clock),
    .reset        (reset),
    .sequence_in  (sequence_in),
    .detector_out (detector_out)
  );

  // 10 ns clock period, rising edges at 5, 15, 25, ...
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Safety net so the bench always ends even if something stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Compare the state register and the output against expected values.
  task automatic checkOutput(input string tag, input logic [2:0] expState,
                             input logic expOut);
    logic [2:0] obsState;
    obsState = dut.current_state;
    assertCount++;
    assert (obsState === expState) else begin
      failCount++;
      $error("[TB] FAIL %s state: observed %b expected %b", tag, obsState, expState);
    end
    assertCount++;
    assert (detector_out === expOut) else begin
      failCount++;
      $error("[TB] FAIL %s out: observed %b expected %b", tag, detector_out, expOut);
    end
  endtask

  // Compare the combinational next-state value (used for illegal codes).
  task automatic checkNext(input string tag, input logic [2:0] expNext);
    logic [2:0] obsNext;
    obsNext = dut.next_state;
    assertCount++;
    assert (obsNext === expNext) else begin
      failCount++;
      $error("[TB] FAIL %s next: observed %b expected %b", tag, obsNext, expNext);
    end
  endtask

  // Drive one bit, let the rising edge sample it, then settle 1 ns past it.
  task automatic applyStimulus(input logic bitIn);
    sequence_in = bitIn;
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [3:0] pat;
    assertCount = 0;
    failCount   = 0;
    reset       = 1'b1;
    sequence_in = 1'b0;
    pat         = PATTERN;

    // Reset held for 3 edges with the input toggling: state must stay S0.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(i[0] ? 1'b0 : 1'b1);
      checkOutput("reset_hold", 3'b000, 1'b0);
    end
    #2 reset = 1'b0;
    #1 checkOutput("reset_release", 3'b000, 1'b0);

    // Basic hit: 1,0,1,1 taken from the package pattern, MSB first.
    applyStimulus(pat[3]); checkOutput("hit_b1", 3'b001, 1'b0);
    applyStimulus(pat[2]); checkOutput("hit_b2", 3'b010, 1'b0);
    applyStimulus(pat[1]); checkOutput("hit_b3", 3'b011, 1'b0);
    applyStimulus(pat[0]); checkOutput("hit_b4", 3'b100, 1'b1);

    // Overlap: continuing with 0,1,1 completes "1011" again 3 cycles later.
    applyStimulus(1'b0); checkOutput("ovl_0", 3'b010, 1'b0);
    applyStimulus(1'b1); checkOutput("ovl_1", 3'b011, 1'b0);
    applyStimulus(1'b1); checkOutput("ovl_hit", 3'b100, 1'b1);
    applyStimulus(1'b1); checkOutput("ovl_after", 3'b001, 1'b0);

    // Non-matching: a run of ones parks in S1.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1);
      checkOutput("ones", 3'b001, 1'b0);
    end

    // Non-matching: 1,0,0 falls back to S0.
    applyStimulus(1'b1); checkOutput("100_a", 3'b001, 1'b0);
    applyStimulus(1'b0); checkOutput("100_b", 3'b010, 1'b0);
    applyStimulus(1'b0); checkOutput("100_c", 3'b000, 1'b0);

    // Non-matching: 1,0,1,0 ends in S2 with no output.
    applyStimulus(1'b1); checkOutput("1010_a", 3'b001, 1'b0);
    applyStimulus(1'b0); checkOutput("1010_b", 3'b010, 1'b0);
    applyStimulus(1'b1); checkOutput("1010_c", 3'b011, 1'b0);
    applyStimulus(1'b0); checkOutput("1010_d", 3'b010, 1'b0);

    // Back to S0, then 1,0,1 and an asynchronous reset between edges.
    applyStimulus(1'b0); checkOutput("mid_idle", 3'b000, 1'b0);
    applyStimulus(1'b1); checkOutput("mid_a", 3'b001, 1'b0);
    applyStimulus(1'b0); checkOutput("mid_b", 3'b010, 1'b0);
    applyStimulus(1'b1); checkOutput("mid_c", 3'b011, 1'b0);
    sequence_in = 1'b1;
    #2 reset = 1'b1;
    #1 checkOutput("mid_async_rst", 3'b000, 1'b0);
    #1 reset = 1'b0;
    applyStimulus(1'b1); checkOutput("mid_after_rst", 3'b001, 1'b0);
    applyStimulus(1'b0); checkOutput("mid_post_b", 3'b010, 1'b0);
    applyStimulus(1'b1); checkOutput("mid_post_c", 3'b011, 1'b0);
    applyStimulus(1'b1); checkOutput("mid_post_hit", 3'b100, 1'b1);

    // Settle into S0 before the illegal-state checks.
    applyStimulus(1'b0); checkOutput("pre_ill_a", 3'b010, 1'b0);
    applyStimulus(1'b0); checkOutput("pre_ill_b", 3'b000, 1'b0);

    // Illegal code 3'b110: output low, next state S0 for either input.
    #2 force dut.current_state = state_t'(3'b110);
    sequence_in = 1'b0;
    #1 checkOutput("ill110_out", 3'b110, 1'b0);
    checkNext("ill110_in0", 3'b000);
    sequence_in = 1'b1;
    #1 checkNext("ill110_in1", 3'b000);
    sequence_in = 1'b0;
    #1 release dut.current_state;
    @(posedge clock);
    #1 checkOutput("ill110_edge", 3'b000, 1'b0);

    // Illegal code 3'b111 behaves the same way.
    #2 force dut.current_state = state_t'(3'b111);
    sequence_in = 1'b1;
    #1 checkOutput("ill111_out", 3'b111, 1'b0);
    checkNext("ill111_in1", 3'b000);
    sequence_in = 1'b0;
    #1 checkNext("ill111_in0", 3'b000);
    #1 release dut.current_state;
    @(posedge clock);
    #1 checkOutput("ill111_edge", 3'b000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule
